// File: rtl/reg_file_tagged.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Two registered read ports, one rename per cycle, one commit write-back per cycle, global flush.
module reg_file_tagged #(
  parameter int LEN    = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [LEN-1:0]    rs1_data,
  output logic              rs1_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [LEN-1:0]    rs2_data,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs2_tag,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cm_valid,
  input  logic [ADDR_W-1:0] cm_rd,
  input  logic [TAG_W-1:0]  cm_tag,
  input  logic [LEN-1:0]    cm_data,
  input  logic              flush
);

  localparam int REG_NUM = 2 ** ADDR_W;

  logic [LEN-1:0]    data_q [REG_NUM];
  logic [LEN-1:0]    data_d [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];
  logic [TAG_W-1:0]  tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;

  logic [ADDR_W-1:0] rdIdx    [2];
  logic [LEN-1:0]    viewData [2];
  logic              viewBusy [2];
  logic [TAG_W-1:0]  viewTag  [2];
  logic [LEN-1:0]    outData_q [2];
  logic              outBusy_q [2];
  logic [TAG_W-1:0]  outTag_q  [2];

  logic cmHit, issueHit;

  assign cmHit    = cm_valid && (cm_rd != '0);
  assign issueHit = issue_valid && (issue_rd != '0) && !flush;

  assign rdIdx[0] = rs1;
  assign rdIdx[1] = rs2;

  // Reads see this cycle's commit (data bypass and tag-matched release) but not issue or flush.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      viewData[p] = data_q[rdIdx[p]];
      viewBusy[p] = busy_q[rdIdx[p]];
      viewTag[p]  = tag_q[rdIdx[p]];
      if (cmHit && (cm_rd == rdIdx[p])) begin
        viewData[p] = cm_data;
        if (tag_q[rdIdx[p]] == cm_tag) viewBusy[p] = 1'b0;
      end
      if (rdIdx[p] == '0) begin
        viewData[p] = '0;
        viewBusy[p] = 1'b0;
        viewTag[p]  = '0;
      end
    end
  end

  // Priority from lowest to highest: commit release, issue rename, flush clear.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (cmHit) begin
      data_d[cm_rd] = cm_data;
      if (tag_q[cm_rd] == cm_tag) busy_d[cm_rd] = 1'b0;
    end
    if (issueHit) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
      for (int p = 0; p < 2; p++) begin
        outData_q[p] <= '0;
        outBusy_q[p] <= 1'b0;
        outTag_q[p]  <= '0;
      end
    end else if (rdy_in) begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      for (int p = 0; p < 2; p++) begin
        outData_q[p] <= viewData[p];
        outBusy_q[p] <= viewBusy[p];
        outTag_q[p]  <= viewTag[p];
      end
    end
  end

  assign rs1_data = outData_q[0];
  assign rs1_busy = outBusy_q[0];
  assign rs1_tag  = outTag_q[0];
  assign rs2_data = outData_q[1];
  assign rs2_busy = outBusy_q[1];
  assign rs2_tag  = outTag_q[1];

endmodule

// File: tb/tb_reg_file_tagged.sv
// Directed + randomized scoreboard bench for reg_file_tagged.
// Expected read results are pushed when a step is driven and popped after the next enabled edge.
module tb_reg_file_tagged;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [3:0]  cm_tag;
  logic [31:0] cm_data;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d1;
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] d2;
    logic        b2;
    logic [3:0]  t2;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;

  logic [31:0] mData [32];
  logic [3:0]  mTag  [32];
  logic        mBusy [32];

  reg_file_tagged #(.LEN(32), .ADDR_W(5), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_data(rs2_data), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mData[i] = '0;
      mTag[i]  = '0;
      mBusy[i] = 1'b0;
    end
    lastExp = '0;
    expQ.delete();
  endtask

  function automatic logic [36:0] modelRead(input logic [4:0] a, input logic cv,
                                            input logic [4:0] crd, input logic [3:0] ctag,
                                            input logic [31:0] cdata);
    logic [31:0] d;
    logic        b;
    logic [3:0]  t;
    if (a == 0) return '0;
    d = mData[a];
    b = mBusy[a];
    t = mTag[a];
    if (cv && crd == a) begin
      d = cdata;
      if (mTag[a] == ctag) b = 1'b0;
    end
    return {d, b, t};
  endfunction

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (expQ.size() > 0)
    else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    checks--;
    e = expQ.pop_front();
    cmp("rs1_data", rs1_data, e.d1);
    cmp("rs1_busy", {31'b0, rs1_busy}, {31'b0, e.b1});
    cmp("rs1_tag",  {28'b0, rs1_tag},  {28'b0, e.t1});
    cmp("rs2_data", rs2_data, e.d2);
    cmp("rs2_busy", {31'b0, rs2_busy}, {31'b0, e.b2});
    cmp("rs2_tag",  {28'b0, rs2_tag},  {28'b0, e.t2});
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2,
                               input logic iv, input logic [4:0] ird, input logic [3:0] itag,
                               input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                               input logic [31:0] cdata, input logic fl, input logic rdy);
    exp_t e;
    logic [36:0] v1, v2;
    rs1 = r1; rs2 = r2;
    issue_valid = iv; issue_rd = ird; issue_tag = itag;
    cm_valid = cv; cm_rd = crd; cm_tag = ctag; cm_data = cdata;
    flush = fl; rdy_in = rdy;
    if (rdy) begin
      v1 = modelRead(r1, cv, crd, ctag, cdata);
      v2 = modelRead(r2, cv, crd, ctag, cdata);
      e = {v1, v2};
      if (cv && crd != 0) begin
        mData[crd] = cdata;
        if (mTag[crd] == ctag) mBusy[crd] = 1'b0;
      end
      if (iv && ird != 0 && !fl) begin
        mBusy[ird] = 1'b1;
        mTag[ird]  = itag;
      end
      if (fl) for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
      lastExp = e;
    end else begin
      e = lastExp;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic readRegs(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(r1, r2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    applyStimulus(0, 0, 1, rd, tag, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic idleInputs();
    rs1 = 0; rs2 = 0; rdy_in = 1'b1;
    issue_valid = 0; issue_rd = 0; issue_tag = 0;
    cm_valid = 0; cm_rd = 0; cm_tag = 0; cm_data = 0; flush = 0;
  endtask

  task automatic checkAllZero();
    expQ.push_back('0);
    checkOutput();
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero();
    rst = 1'b0;
    applyStimulus(3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) readRegs(5'(i), 5'(31 - i));

    $display("[TB] rename/commit");
    applyStimulus(5, 0, 1, 5, 3, 0, 0, 0, 0, 0, 1);
    readRegs(5, 0);
    applyStimulus(5, 0, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 1);
    readRegs(5, 5);

    $display("[TB] same-cycle bypass");
    issue(7, 2);
    applyStimulus(0, 7, 0, 0, 0, 1, 7, 2, 32'h55, 0, 1);
    readRegs(7, 7);

    $display("[TB] stale commit and issue race");
    issue(9, 4);
    applyStimulus(9, 9, 0, 0, 0, 1, 9, 1, 32'hA, 0, 1);
    readRegs(9, 0);
    applyStimulus(9, 5, 1, 9, 6, 1, 9, 4, 32'hB, 0, 1);
    readRegs(9, 9);
    applyStimulus(11, 12, 1, 11, 7, 1, 12, 0, 32'h1212, 0, 1);
    readRegs(11, 12);

    $display("[TB] flush");
    issue(1, 1);
    issue(2, 2);
    issue(3, 3);
    readRegs(1, 3);
    applyStimulus(2, 3, 1, 2, 8, 1, 3, 9, 32'h33, 1, 1);
    readRegs(1, 2);
    readRegs(3, 2);

    $display("[TB] x0 and stall");
    applyStimulus(0, 0, 1, 0, 5, 1, 0, 5, 32'h1, 0, 1);
    readRegs(0, 0);
    readRegs(4, 9);
    applyStimulus(4, 4, 1, 4, 2, 1, 4, 0, 32'h44, 1, 0);
    readRegs(4, 0);

    $display("[TB] reset mid-operation");
    issue(10, 5);
    applyStimulus(10, 5, 0, 0, 0, 1, 5, 0, 32'h77, 0, 1);
    issue_valid = 1; issue_rd = 13; issue_tag = 9;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAllZero();
    idleInputs();
    #1 rst = 1'b0;
    readRegs(10, 5);
    readRegs(13, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                    32'($urandom), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
